modulo_controle_ataque: RTL and testbench
=========================================

// Module: modulo_controle_ataque
// PURPOSE
//  Attack controller upstream of the display/matrix stage: takes the player's 6-bit coordinate and a
//  confirm button, validates the shot against a 7x5 board, marks it in the attack matrix, compares it
//  with the ship-position matrix and produces the 2-bit shot status, the latched attack coordinate
//  and the attack matrix that drive the 7-seg display and the matrix muxes. Also tracks hits, remaining
//  shots and win/lose.
// PARAMETERS
//  ROWS       7   board rows (row field coord_in[5:3]); fixed by 35-bit matrix layout
//  COLS       5   board columns (col field coord_in[2:0])
//  MAX_SHOTS  20  shots allowed per game, 1..63
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  clr        in   1   asynchronous, active-low reset
//  coord_in   in   6   {row[2:0], col[2:0]} from switches, sampled only on accepted confirm
//  btn_conf   in   1   confirm push button, asynchronous, active-high level
//  m_po       in   35  ship-position matrix, bit set = ship cell
//  status     out  2   00 none, 01 water (miss), 10 hit, 11 invalid/repeated shot
//  coord_at   out  6   coordinate of last processed shot
//  m_at       out  35  attack matrix, bit set = cell already shot
//  hits       out  6   number of ship cells hit
//  shots_left out  6   remaining valid shots
//  shot_done  out  1   one-cycle pulse when a shot result is published
//  win        out  1   all ship cells hit (sticky until reset)
//  lose       out  1   shots exhausted with ships remaining (sticky until reset)
// BEHAVIOUR
//  - Cell index: row r, col c -> bit 34-(r*COLS+c); row 0 = m_at[34:30], row 6 = m_at[4:0]. Same for m_po.
//  - clr=0: status=00, coord_at=0, m_at=0, hits=0, shots_left=MAX_SHOTS, shot_done=0, win=0, lose=0,
//    sync/edge regs=0, state=LOAD. Applies immediately, also mid-shot; no partial update survives.
//  - btn_conf passes a 2-FF synchronizer; press = sync high while previous sync sample low (rising edge).
//    Held button = one press. Button sampled high at edge E -> FSM sees press at edge E+2.
//  - States: LOAD, IDLE, CHECK, DONE.
//    LOAD: first edge after reset release; latch m_po into ship_reg, ship_total=popcount (6 bits).
//      ship_total=0 -> DONE with win=1; else -> IDLE.
//    IDLE: on press latch coord_in into coord_at, -> CHECK. No press -> stay.
//    CHECK (1 cycle): evaluate latched coord, publish result, shot_done=1 this edge:
//      row>=ROWS or col>=COLS -> status=11, no other change.
//      m_at[idx]=1 (repeat) -> status=11, no other change.
//      else m_at[idx]<=1, shots_left-=1; ship_reg[idx]=1 -> status=10, hits+=1; else status=01.
//      Next: hits_next==ship_total -> DONE, win=1; else shots_left_next==0 -> DONE, lose=1; else IDLE.
//    DONE: terminal; presses ignored; all outputs hold; only clr leaves.
//  - Latency: press seen at edge P -> coord_at updates at P; status/m_at/hits/shots_left/shot_done at P+1.
//  - Press arriving while in CHECK is dropped (not queued); next shot needs a new rising edge.
//  - Invalid/repeated shots consume no shot. Final shot that both completes the fleet and exhausts
//    shots -> win=1, lose=0 (win priority). win and lose never both 1.
//  - status holds last result until next CHECK. m_po changes after LOAD are ignored until next reset.
//  - hits <= ship_total <= 35; shots_left never wraps below 0.
// TESTING
//  1 Reset, m_po bit34 only (ship_total=1); coord_in=6'o00, press -> status=10, m_at[34]=1, hits=1,
//    win=1, shot_done one pulse, state DONE; further presses change nothing.
//  2 m_po=0x0_0000_0003; shoot 6'o01 -> status=01, m_at[33]=1, shots_left=MAX_SHOTS-1; shoot 6'o01
//    again -> status=11, m_at/shots_left unchanged.
//  3 coord_in=6'o70 (row 7) and 6'o05 (col 5) -> status=11 each, m_at=0, shots_left=MAX_SHOTS.
//  4 MAX_SHOTS=3, two ships; three misses -> after third: lose=1, win=0, shots_left=0, DONE.
//  5 Hold btn_conf high 50 cycles -> exactly one shot_done pulse; second press during CHECK dropped.
//  6 Assert clr low during CHECK cycle -> all outputs at reset values next cycle; new game works after.

Source files
------------

// File: rtl/modulo_controle_ataque.sv
// Attack controller: validates a synchronized shot, marks the attack matrix,
// scores it against the latched ship matrix and tracks hits/shots/win/lose.
module modulo_controle_ataque #(
  parameter int unsigned ROWS      = 7,
  parameter int unsigned COLS      = 5,
  parameter int unsigned MAX_SHOTS = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [5:0]  coord_in,
  input  logic        btn_conf,
  input  logic [34:0] m_po,
  output logic [1:0]  status,
  output logic [5:0]  coord_at,
  output logic [34:0] m_at,
  output logic [5:0]  hits,
  output logic [5:0]  shots_left,
  output logic        shot_done,
  output logic        win,
  output logic        lose
);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_CHECK, S_DONE} state_t;

  state_t      r_state;
  logic        r_sync0;
  logic        r_sync1;
  logic        r_sync_prev;
  logic [34:0] r_ship;
  logic [5:0]  r_total;

  logic        w_press;
  logic [2:0]  w_row;
  logic [2:0]  w_col;
  logic        w_in_range;
  logic [5:0]  w_lin;
  logic [5:0]  w_idx;
  logic        w_repeat;
  logic        w_hit;
  logic [5:0]  w_hits_next;
  logic [5:0]  w_left_next;

  assign w_press     = r_sync1 & ~r_sync_prev;
  assign w_row       = coord_at[5:3];
  assign w_col       = coord_at[2:0];
  assign w_in_range  = (w_row < 3'(ROWS)) && (w_col < 3'(COLS));
  assign w_lin       = 6'(w_row) * 6'(COLS) + 6'(w_col);
  // Row 0 / col 0 lives at the MSB of the 35-bit matrices.
  assign w_idx       = 6'(ROWS * COLS - 1) - w_lin;
  assign w_repeat    = w_in_range && m_at[w_idx];
  assign w_hit       = w_in_range && r_ship[w_idx];
  assign w_hits_next = hits + {5'b0, w_hit};
  assign w_left_next = shots_left - 6'd1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_LOAD;
      r_sync0     <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_ship      <= '0;
      r_total     <= '0;
      status      <= 2'b00;
      coord_at    <= '0;
      m_at        <= '0;
      hits        <= '0;
      shots_left  <= 6'(MAX_SHOTS);
      shot_done   <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      r_sync0     <= btn_conf;
      r_sync1     <= r_sync0;
      r_sync_prev <= r_sync1;
      shot_done   <= 1'b0;

      case (r_state)
        S_LOAD: begin
          r_ship  <= m_po;
          r_total <= 6'($countones(m_po));
          if (m_po == '0) begin
            win     <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (w_press) begin
            coord_at <= coord_in;
            r_state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          shot_done <= 1'b1;
          if (!w_in_range || w_repeat) begin
            status  <= 2'b11;
            r_state <= S_IDLE;
          end else begin
            m_at[w_idx] <= 1'b1;
            shots_left  <= w_left_next;
            hits        <= w_hits_next;
            status      <= w_hit ? 2'b10 : 2'b01;
            // Completing the fleet wins even when it also spends the last shot.
            if (w_hits_next == r_total) begin
              win     <= 1'b1;
              r_state <= S_DONE;
            end else if (w_left_next == '0) begin
              lose    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: r_state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_controle_ataque.sv
// Directed-vector bench for modulo_controle_ataque; expected shot results are
// queued at stimulus time and checked by a monitor on each shot_done pulse.
module tb_modulo_controle_ataque;

  logic        clk;
  logic        clr;
  logic [5:0]  coord_in;
  logic        btn_conf;
  logic [34:0] m_po;
  logic [1:0]  status;
  logic [5:0]  coord_at;
  logic [34:0] m_at;
  logic [5:0]  hits;
  logic [5:0]  shots_left;
  logic        shot_done;
  logic        win;
  logic        lose;

  modulo_controle_ataque #(.ROWS(7), .COLS(5), .MAX_SHOTS(20)) dut (
    .clk        (clk),
    .clr        (clr),
    .coord_in   (coord_in),
    .btn_conf   (btn_conf),
    .m_po       (m_po),
    .status     (status),
    .coord_at   (coord_at),
    .m_at       (m_at),
    .hits       (hits),
    .shots_left (shots_left),
    .shot_done  (shot_done),
    .win        (win),
    .lose       (lose)
  );

  typedef struct {
    logic [1:0]  st;
    logic [5:0]  co;
    logic [34:0] mat;
    logic [5:0]  h;
    logic [5:0]  left;
    logic        w;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every published result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (clr && shot_done) begin
      if (q.size() == 0) begin
        chk("unexpected_shot_done", 64'(shot_done), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("status",     64'(status),     64'(e.st));
        chk("coord_at",   64'(coord_at),   64'(e.co));
        chk("m_at",       64'(m_at),       64'(e.mat));
        chk("hits",       64'(hits),       64'(e.h));
        chk("shots_left", 64'(shots_left), 64'(e.left));
        chk("win",        64'(win),        64'(e.w));
        chk("lose",       64'(lose),       64'(e.l));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_status"},     64'(status),     64'(0));
    chk({tag, "_coord_at"},   64'(coord_at),   64'(0));
    chk({tag, "_m_at"},       64'(m_at),       64'(0));
    chk({tag, "_hits"},       64'(hits),       64'(0));
    chk({tag, "_shots_left"}, 64'(shots_left), 64'(20));
    chk({tag, "_shot_done"},  64'(shot_done),  64'(0));
    chk({tag, "_win"},        64'(win),        64'(0));
    chk({tag, "_lose"},       64'(lose),       64'(0));
  endtask

  task automatic do_reset(input logic [34:0] mpo, input bit check);
    @(negedge clk);
    clr      = 1'b0;
    btn_conf = 1'b0;
    m_po     = mpo;
    @(negedge clk);
    if (check) check_reset_values("reset");
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_hold(input logic [5:0] c, input int unsigned n);
    @(negedge clk);
    coord_in = c;
    btn_conf = 1'b1;
    repeat (n) @(negedge clk);
    btn_conf = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic shoot(input logic [5:0] c, input logic [1:0] st, input logic [34:0] mat,
                       input logic [5:0] h, input logic [5:0] left, input logic w, input logic l);
    exp_t e;
    e.st = st; e.co = c; e.mat = mat; e.h = h; e.left = left; e.w = w; e.l = l;
    q.push_back(e);
    press_hold(c, 2);
  endtask

  initial begin
    logic [34:0] mat;
    clr      = 1'b0;
    btn_conf = 1'b0;
    coord_in = '0;
    m_po     = '0;

    // Single-ship board: one hit wins, later presses are ignored.
    do_reset(35'h4_0000_0000, 1'b1);
    shoot(6'o00, 2'b10, 35'h4_0000_0000, 6'd1, 6'd19, 1'b1, 1'b0);
    press_hold(6'o15, 2);
    chk("done_status",   64'(status),   64'(2'b10));
    chk("done_coord_at", 64'(coord_at), 64'(0));
    chk("done_m_at",     64'(m_at),     64'(35'h4_0000_0000));
    chk("done_win",      64'(win),      64'(1));

    // Miss, repeat, then sink both ships in the bottom-right corner.
    do_reset(35'h0_0000_0003, 1'b0);
    shoot(6'o01, 2'b01, 35'h2_0000_0000, 6'd0, 6'd19, 1'b0, 1'b0);
    shoot(6'o01, 2'b11, 35'h2_0000_0000, 6'd0, 6'd19, 1'b0, 1'b0);
    shoot(6'o63, 2'b10, 35'h2_0000_0002, 6'd1, 6'd18, 1'b0, 1'b0);
    shoot(6'o64, 2'b10, 35'h2_0000_0003, 6'd2, 6'd17, 1'b1, 1'b0);

    // Out-of-board coordinates consume nothing.
    do_reset(35'h0_0000_0003, 1'b0);
    shoot(6'o70, 2'b11, 35'h0, 6'd0, 6'd20, 1'b0, 1'b0);
    shoot(6'o05, 2'b11, 35'h0, 6'd0, 6'd20, 1'b0, 1'b0);
    shoot(6'o07, 2'b11, 35'h0, 6'd0, 6'd20, 1'b0, 1'b0);

    // Twenty misses exhaust the shots.
    do_reset(35'h0_0000_0003, 1'b0);
    mat = '0;
    for (int k = 0; k < 20; k++) begin
      mat[34 - k] = 1'b1;
      shoot({3'(k / 5), 3'(k % 5)}, 2'b01, mat, 6'd0, 6'(19 - k), 1'b0, k == 19);
    end
    press_hold(6'o64, 2);
    chk("lose_hold_lose",  64'(lose),       64'(1));
    chk("lose_hold_win",   64'(win),        64'(0));
    chk("lose_hold_left",  64'(shots_left), 64'(0));
    chk("lose_hold_m_at",  64'(m_at),       64'(mat));

    // Last shot both sinks the fleet and spends the final shot: win wins.
    do_reset(35'h0_0000_0003, 1'b0);
    mat = '0;
    for (int k = 0; k < 18; k++) begin
      mat[34 - k] = 1'b1;
      shoot({3'(k / 5), 3'(k % 5)}, 2'b01, mat, 6'd0, 6'(19 - k), 1'b0, 1'b0);
    end
    mat[1] = 1'b1;
    shoot(6'o63, 2'b10, mat, 6'd1, 6'd1, 1'b0, 1'b0);
    mat[0] = 1'b1;
    shoot(6'o64, 2'b10, mat, 6'd2, 6'd0, 1'b1, 1'b0);

    // A button held for 50 cycles is a single shot.
    do_reset(35'h0_0000_0003, 1'b0);
    begin
      exp_t e;
      e.st = 2'b01; e.co = 6'o00; e.mat = 35'h4_0000_0000; e.h = 6'd0; e.left = 6'd19;
      e.w = 1'b0; e.l = 1'b0;
      q.push_back(e);
    end
    press_hold(6'o00, 50);
    chk("held_left", 64'(shots_left), 64'(19));

    // Reset asserted while the shot is being evaluated.
    do_reset(35'h0_0000_0003, 1'b0);
    @(negedge clk);
    coord_in = 6'o12;
    btn_conf = 1'b1;
    @(negedge clk);
    @(negedge clk);
    btn_conf = 1'b0;
    @(negedge clk);
    chk("check_coord_at", 64'(coord_at), 64'(6'o12));
    clr  = 1'b0;
    m_po = 35'h4_0000_0000;
    @(negedge clk);
    check_reset_values("midshot");
    clr = 1'b1;
    @(negedge clk);
    shoot(6'o00, 2'b10, 35'h4_0000_0000, 6'd1, 6'd19, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    chk("pending_results", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
